// File: rtl/fa_chunk_adder.sv
// -----------------------------------------------------------------------------
// fa_chunk_adder
//
// Multi-cycle adder: s = a + b + ci (mod 2^WIDTH), co = carry out of bit WIDTH-1.
// CHUNK bits are added per clock through a registered carry, so the
// combinational path is one CHUNK-bit ripple regardless of WIDTH.
// A result takes NCHUNK + 2 cycles from acceptance to the next possible
// acceptance (IDLE -> NCHUNK x BUSY -> DONE -> IDLE).
//
// Parameters:
//   WIDTH  operand / sum width; must be an exact multiple of CHUNK
//   CHUNK  bits added per clock, 1 <= CHUNK <= WIDTH
//
// Ports:
//   clk    clock, all state on rising edge
//   rst    synchronous active-high reset, priority over every other input
//   start  request, accepted only on an edge where ready = 1
//   a, b   operands, sampled at acceptance
//   ci     carry in, sampled at acceptance
//   ready  high in IDLE only
//   done   one-cycle pulse: s/co (and ovf) were just updated
//   s      registered sum, held until the next completion
//   co     registered carry out
//   ovf    signed (two's-complement) overflow; only with FA_OVF_EN defined
//
// Build option: define FA_OVF_EN to add the ovf port and its logic.
// -----------------------------------------------------------------------------
module fa_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef FA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             done_q, done_d;
`ifdef FA_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        s_d     = s_q;
        co_d    = co_q;
        done_d  = 1'b0;
`ifdef FA_OVF_EN
        ovf_d   = ovf_q;
`endif

        a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                work_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d = chunk_res[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    // work_d already holds the final chunk here, so s never
                    // exposes a partially built sum.
                    s_d     = work_d;
                    co_d    = chunk_res[CHUNK];
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = DONE;
`ifdef FA_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit:
                    // sum = a ^ b ^ cin  =>  cin = a ^ b ^ sum.
                    ovf_d = (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1])
                            ^ chunk_res[CHUNK];
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef FA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            s_q     <= s_d;
            co_q    <= co_d;
            done_q  <= done_d;
`ifdef FA_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign s     = s_q;
    assign co    = co_q;
`ifdef FA_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_fa_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_fa_chunk_adder
//
// Three instances (CHUNK = 4, 1, 16 at WIDTH = 16) share operands, carry in
// and reset; each has its own start so a single instance can be exercised
// alone. Expected sums come from plain integer arithmetic a + b + ci.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fa_chunk_adder;

    localparam int W = 16;
    localparam int N_RANDOM = 1500;
    localparam int WINDOW = 19;

    logic          clk;
    logic          rst;
    logic [2:0]    start_v;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          ci_in;

    wire  [2:0]    ready_v;
    wire  [2:0]    done_v;
    wire  [2:0]    co_v;
    wire  [W-1:0]  s_v [3];
`ifdef FA_OVF_EN
    wire  [2:0]    ovf_v;
`endif

    // Cycles from the falling edge after acceptance to the one showing done.
    int lat [3] = '{4, 16, 1};

    int tests_run = 0;
    int tests_failed = 0;

    fa_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in), .b(b_in), .ci(ci_in),
        .ready(ready_v[0]), .done(done_v[0]), .s(s_v[0]), .co(co_v[0])
`ifdef FA_OVF_EN
        , .ovf(ovf_v[0])
`endif
    );

    fa_chunk_adder #(.WIDTH(W), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in), .b(b_in), .ci(ci_in),
        .ready(ready_v[1]), .done(done_v[1]), .s(s_v[1]), .co(co_v[1])
`ifdef FA_OVF_EN
        , .ovf(ovf_v[1])
`endif
    );

    fa_chunk_adder #(.WIDTH(W), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in), .b(b_in), .ci(ci_in),
        .ready(ready_v[2]), .done(done_v[2]), .s(s_v[2]), .co(co_v[2])
`ifdef FA_OVF_EN
        , .ovf(ovf_v[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One add on the instances selected by en. With poke set, start is
    // re-asserted with different operands during the first BUSY cycles.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_ci, input logic [2:0] en, input bit poke);
        logic [W:0]   full;
        logic         exp_ovf;
        int           first [3];
        int           pulses [3];
        logic [W-1:0] prev_s [3];
        logic [W-1:0] cap_s [3];
        logic         cap_co [3];
        logic         cap_ovf [3];
        bit           stable [3];
        int           guard;

        full    = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_ci};
        exp_ovf = (op_a[W-1] == op_b[W-1]) && (full[W-1] != op_a[W-1]);

        guard = 0;
        while (((ready_v & en) != en) && (guard < 40)) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_start", {29'd0, ready_v & en}, {29'd0, en});

        for (int k = 0; k < 3; k++) begin
            first[k]   = -1;
            pulses[k]  = 0;
            prev_s[k]  = s_v[k];
            cap_s[k]   = '0;
            cap_co[k]  = 1'b0;
            cap_ovf[k] = 1'b0;
            stable[k]  = 1'b1;
        end

        a_in    = op_a;
        b_in    = op_b;
        ci_in   = op_ci;
        start_v = en;
        @(negedge clk);
        // Operands must have been captured at acceptance.
        start_v = '0;
        a_in    = W'($urandom);
        b_in    = W'($urandom);
        ci_in   = 1'($urandom_range(0, 1));

        for (int cyc = 0; cyc < WINDOW; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (en[k]) begin
                    if (done_v[k]) begin
                        pulses[k]++;
                        if (first[k] < 0) begin
                            first[k]  = cyc;
                            cap_s[k]  = s_v[k];
                            cap_co[k] = co_v[k];
`ifdef FA_OVF_EN
                            cap_ovf[k] = ovf_v[k];
`endif
                        end
                    end else if (first[k] < 0 && s_v[k] !== prev_s[k]) begin
                        stable[k] = 1'b0;
                    end
                end
            end
            if (poke && cyc < 3) begin
                start_v = en;
                a_in    = 16'hAAAA;
                b_in    = 16'h5555;
            end else begin
                start_v = '0;
            end
            @(negedge clk);
        end

        for (int k = 0; k < 3; k++) begin
            if (en[k]) begin
                check($sformatf("latency[%0d]", k), first[k], lat[k]);
                check($sformatf("done_pulses[%0d]", k), pulses[k], 1);
                check($sformatf("s_held_before_done[%0d]", k), {31'd0, stable[k]}, 32'd1);
                check($sformatf("sum_co[%0d]", k), {15'd0, cap_co[k], cap_s[k]}, {15'd0, full});
                check($sformatf("s_held_after_done[%0d]", k), {16'd0, s_v[k]}, {16'd0, full[W-1:0]});
`ifdef FA_OVF_EN
                check($sformatf("ovf[%0d]", k), {31'd0, cap_ovf[k]}, {31'd0, exp_ovf});
`endif
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;

        // Reset with start asserted: nothing may be accepted.
        rst     = 1'b1;
        start_v = 3'b111;
        a_in    = 16'hFFFF;
        b_in    = 16'hFFFF;
        ci_in   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ready[%0d]", k), {31'd0, ready_v[k]}, 32'd1);
            check($sformatf("rst_done[%0d]", k), {31'd0, done_v[k]}, 32'd0);
            check($sformatf("rst_s[%0d]", k), {16'd0, s_v[k]}, 32'd0);
            check($sformatf("rst_co[%0d]", k), {31'd0, co_v[k]}, 32'd0);
`ifdef FA_OVF_EN
            check($sformatf("rst_ovf[%0d]", k), {31'd0, ovf_v[k]}, 32'd0);
`endif
        end
        rst     = 1'b0;
        start_v = '0;
        @(negedge clk);
        check("no_accept_in_reset", {29'd0, ready_v}, 32'd7);

        // Directed: basic sum with exact latency on CHUNK=4.
        run_op(16'h1234, 16'h4321, 1'b0, 3'b001, 1'b0);
        check("dir_5555", {16'd0, s_v[0]}, 32'h5555);

        // Full ripple of the carry across every chunk boundary.
        run_op(16'hFFFF, 16'h0000, 1'b1, 3'b111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ripple_s[%0d]", k), {16'd0, s_v[k]}, 32'h0000);
            check($sformatf("ripple_co[%0d]", k), {31'd0, co_v[k]}, 32'd1);
        end

        // Signed overflow corners.
        run_op(16'h7FFF, 16'h0001, 1'b0, 3'b111, 1'b0);
        check("ovf_pos_s", {16'd0, s_v[0]}, 32'h8000);
        run_op(16'h8000, 16'h8000, 1'b0, 3'b111, 1'b0);
        check("ovf_neg_co", {31'd0, co_v[0]}, 32'd1);

        // start during BUSY must be ignored.
        run_op(16'h0001, 16'h0001, 1'b0, 3'b001, 1'b1);
        check("busy_ignored", {16'd0, s_v[0]}, 32'h0002);
        check("busy_ready_back", {31'd0, ready_v[0]}, 32'd1);

        // Abort: reset on the second BUSY edge.
        a_in    = 16'h1234;
        b_in    = 16'h4321;
        ci_in   = 1'b0;
        start_v = 3'b001;
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, ready_v[0]}, 32'd1);
        check("abort_s", {16'd0, s_v[0]}, 32'd0);
        check("abort_co", {31'd0, co_v[0]}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_v[0]) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 0);

        // Random operands on all three chunk sizes.
        for (int i = 0; i < N_RANDOM; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 3'b111, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
